// File: rtl/pm_sched.sv
// pm_sched: round-robin scheduler sharing one pre-emphasis datapath y = x - alpha*x[n-1] across NCH channels.
// Define PM_COEF_WR_EN to make alpha a runtime-writable register (coef_we / coef_wdata ports).

module pm_hist_lane (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               we,
    input  logic signed [15:0] d,
    output logic signed [15:0] q
);
    // Clear has priority so a clear coinciding with the CALC write leaves history at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    q <= '0;
        else if (clr)  q <= '0;
        else if (we)   q <= d;
    end
endmodule

module pm_sched #(
    parameter  int NCH   = 4,
    parameter  int ALPHA = 30146,
    localparam int CW    = $clog2(NCH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NCH-1:0]        in_valid,
    input  logic [16*NCH-1:0]     in_data,
    output logic [NCH-1:0]        in_ready,
    input  logic                  clr_hist,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic signed [15:0]    out_data,
    output logic [CW-1:0]         out_ch
`ifdef PM_COEF_WR_EN
    ,
    input  logic                  coef_we,
    input  logic [15:0]           coef_wdata
`endif
);
    typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

    state_t                         state;
    logic [CW-1:0]                  rr_ptr, g, cand, gnt_idx;
    logic                           gnt_found;
    logic signed [15:0]             x, alpha, hsel, scaled;
    logic signed [16:0]             diff;
    logic signed [15:0]             sat;
    logic [NCH-1:0][15:0]           din;
    logic [NCH-1:0][15:0]           hist;

    assign din = in_data;

`ifdef PM_COEF_WR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       alpha <= 16'(ALPHA);
        else if (coef_we) alpha <= coef_wdata;
    end
`else
    assign alpha = 16'(ALPHA);
`endif

    genvar i;
    generate
        for (i = 0; i < NCH; i++) begin : g_lane
            pm_hist_lane u_lane (
                .clk   (clk),
                .rst_n (rst_n),
                .clr   (clr_hist),
                .we    (state == CALC && g == CW'(i)),
                .d     (x),
                .q     (hist[i])
            );
        end
    endgenerate

    // First requesting channel at or above rr_ptr, wrapping around.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NCH; k++) begin
            cand = CW'((int'(rr_ptr) + k) % NCH);
            if (!gnt_found && in_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (rst_n && state == IDLE && gnt_found)
            in_ready = NCH'(1) << gnt_idx;
    end

    // Q0.15 scaling: bits [30:15] of the 32-bit product.
    assign hsel   = hist[g];
    assign scaled = 16'((32'(alpha) * 32'(hsel)) >>> 15);
    assign diff   = {x[15], x} - {scaled[15], scaled};

    always_comb begin
        sat = diff[15:0];
        if (diff[16] != diff[15])
            sat = diff[16] ? 16'sh8000 : 16'sh7fff;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            g         <= '0;
            x         <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
        end else begin
            case (state)
                IDLE: if (gnt_found) begin
                    g     <= gnt_idx;
                    x     <= din[gnt_idx];
                    state <= CALC;
                end
                CALC: begin
                    out_data  <= sat;
                    out_ch    <= g;
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: if (out_ready) begin
                    out_valid <= 1'b0;
                    rr_ptr    <= (g == CW'(NCH - 1)) ? '0 : g + 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pm_sched.sv
// Scoreboard bench for pm_sched: driver pushes model results, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_pm_sched;
    localparam int NCH   = 4;
    localparam int ALPHA = 30146;
    localparam int CW    = $clog2(NCH);

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NCH-1:0]       in_valid = '0;
    logic [16*NCH-1:0]    in_data = '0;
    logic [NCH-1:0]       in_ready;
    logic                 clr_hist = 1'b0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic signed [15:0]   out_data;
    logic [CW-1:0]        out_ch;
`ifdef PM_COEF_WR_EN
    logic                 coef_we = 1'b0;
    logic [15:0]          coef_wdata = '0;
`endif

    pm_sched #(.NCH(NCH), .ALPHA(ALPHA)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .clr_hist  (clr_hist),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ch    (out_ch)
`ifdef PM_COEF_WR_EN
        ,
        .coef_we   (coef_we),
        .coef_wdata(coef_wdata)
`endif
    );

    typedef struct { int ch; int data; } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   tests = 0, fails = 0;
    int   m_hist[NCH];
    int   m_rr = 0;
    int   m_alpha = ALPHA;
    int   rdy_mode = 0;          // 0 always ready, 1 random, 2 held low
    int   cyc = 0, last_hs = -1;
    bit   spacing_chk = 0;
    bit   prev_hold = 0;
    logic signed [15:0] prev_data;
    logic [CW-1:0]      prev_ch;
    logic [NCH-1:0]     r_mask;
    logic [16*NCH-1:0]  r_data;
    int   cnt;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: y = x - floor(alpha*h / 2^15) (wrapped to 16 bits), clamped to int16.
    function automatic int ref_y(input int xv, input int h, input int a);
        int s, d;
        logic signed [15:0] s16;
        s   = (a * h) >>> 15;
        s16 = s[15:0];
        d   = xv - int'(s16);
        if (d > 32767) d = 32767;
        else if (d < -32768) d = -32768;
        return d;
    endfunction

    function automatic int ref_grant(input logic [NCH-1:0] m, input int rr);
        for (int k = 0; k < NCH; k++)
            if (m[(rr + k) % NCH]) return (rr + k) % NCH;
        return -1;
    endfunction

    function automatic logic [16*NCH-1:0] put(input int ch, input int v);
        logic [16*NCH-1:0] r;
        r = '0;
        r[16*ch +: 16] = 16'(v);
        return r;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        foreach (m_hist[i]) m_hist[i] = 0;
        m_rr    = 0;
        m_alpha = ALPHA;
        last_hs = -1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = '1;
        model_reset();
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_ch", out_ch, 0);
        check("rst_in_ready", in_ready, 0);
        repeat (2) @(negedge clk);
        in_valid = '0;
        rst_n    = 1'b1;
    endtask

    task automatic send(input logic [NCH-1:0] mask, input logic [16*NCH-1:0] d, input bit clr_calc);
        int g;
        bit seen;
        exp_t e;
        logic signed [15:0] xs;
        @(posedge clk); #1;
        in_valid = mask;
        in_data  = d;
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (in_ready != 0) seen = 1;
        end
        g = ref_grant(mask, m_rr);
        if (!seen) begin
            tests++; fails++;
            $display("FAIL grant_timeout: no in_ready in 200 cycles, expected ch %0d", g);
            in_valid = '0;
            return;
        end
        check("in_ready_grant", in_ready, 1 << g);
        xs     = d[16*g +: 16];
        e.ch   = g;
        e.data = ref_y(xs, m_hist[g], m_alpha);
        exp_q.push_back(e);
        m_hist[g] = xs;
        m_rr      = (g + 1) % NCH;
        @(posedge clk); #1;
        in_valid = '0;
        if (clr_calc) begin
            clr_hist = 1'b1;
            @(posedge clk); #1;
            clr_hist = 1'b0;
            foreach (m_hist[i]) m_hist[i] = 0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_queue_empty", exp_q.size(), 0);
    endtask

    initial forever begin
        @(posedge clk); #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(3) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold = 0;
        end else if (out_valid) begin
            check("in_ready_busy", in_ready, 0);
            if (prev_hold) begin
                check("hold_data", out_data, prev_data);
                check("hold_ch", out_ch, prev_ch);
            end
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_out: ch %0d data %0d, expected no output", out_ch, out_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out_ch", out_ch, mon_e.ch);
                    check("out_data", out_data, mon_e.data);
                end
                if (spacing_chk && last_hs >= 0) check("out_spacing", cyc - last_hs, 3);
                last_hs   = cyc;
                prev_hold = 0;
            end else begin
                prev_hold = 1;
                prev_data = out_data;
                prev_ch   = out_ch;
            end
        end else begin
            prev_hold = 0;
        end
    end

    initial begin
        #900us;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Round-robin from reset with every channel requesting.
        do_reset();
        rdy_mode    = 0;
        spacing_chk = 1;
        for (int i = 0; i < 5; i++) send('1, {$urandom, $urandom}, 0);
        drain();
        spacing_chk = 0;

        // First-sample passthrough and 0.92 feedback, then saturation corners.
        do_reset();
        send(4'b0001, put(0, 1000), 0);
        send(4'b0001, put(0, 1000), 0);
        send(4'b0010, put(1, -32768), 0);
        send(4'b0010, put(1, 32767), 0);
        send(4'b0010, put(1, -32768), 0);
        drain();

        // Downstream stall: output must hold, nothing new accepted.
        rdy_mode = 2;
        send(4'b1000, put(3, -1234), 0);
        in_valid = '1;
        @(negedge clk);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (out_valid && !out_ready) cnt++;
        end
        check("stall_cycles", cnt, 5);
        in_valid = '0;
        rdy_mode = 0;
        drain();

        // History clear during CALC, then reset during CALC.
        do_reset();
        send(4'b0100, put(2, 300), 0);
        send(4'b0100, put(2, 700), 1);
        send(4'b0100, put(2, 500), 0);
        drain();
        send(4'b0001, put(0, 4321), 0);
        rst_n = 1'b0;
        model_reset();
        #2;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_data", out_data, 0);
        check("midrst_out_ch", out_ch, 0);
        check("midrst_in_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        check("midrst_no_emit", cnt, 0);

`ifdef PM_COEF_WR_EN
        @(posedge clk); #1;
        coef_we = 1'b1; coef_wdata = 16'h0000;
        @(posedge clk); #1;
        coef_we = 1'b0;
        m_alpha = 0;
        send(4'b1000, put(3, 1234), 0);
        send(4'b1000, put(3, 1234), 0);
        drain();
        @(posedge clk); #1;
        coef_we = 1'b1; coef_wdata = 16'(ALPHA);
        @(posedge clk); #1;
        coef_we = 1'b0;
        m_alpha = ALPHA;
`endif

        // Randomized traffic with random backpressure and extreme values mixed in.
        rdy_mode = 1;
        for (int r = 0; r < 150; r++) begin
            r_mask = NCH'($urandom_range(1, (1 << NCH) - 1));
            for (int c = 0; c < NCH; c++) begin
                case ($urandom_range(3))
                    0:       r_data[16*c +: 16] = 16'h8000;
                    1:       r_data[16*c +: 16] = 16'h7fff;
                    default: r_data[16*c +: 16] = 16'($urandom);
                endcase
            end
            send(r_mask, r_data, 0);
            if ($urandom_range(3) == 0) repeat ($urandom_range(3)) @(posedge clk);
        end
        rdy_mode = 0;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
